// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier driving an external 32-bit adder.
// Optional MUL_EARLY_EXIT_EN: leave RUN once no multiplier bits remain set.
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 err,
    output logic [31:0]          adder_a,
    output logic [31:0]          adder_b,
    output logic                 adder_cin,
    input  logic [31:0]          adder_result,
    input  logic                 adder_cout
);

    localparam int unsigned AW = 32;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [AW-1:0]    acc;
    logic [AW-1:0]    mcand;
    logic [WIDTH-1:0] mplr;
    logic [CW-1:0]    cnt;
    logic             accept_c;
    logic             last_c;
    logic             early_c;

    // Adder operands come straight from registers; start never reaches them.
    assign adder_a   = acc;
    assign adder_b   = mplr[0] ? mcand : '0;
    assign adder_cin = 1'b0;

`ifdef MUL_EARLY_EXIT_EN
    assign early_c = (mplr >> 1) == '0;
`else
    assign early_c = 1'b0;
`endif

    assign accept_c = start && ((state_q == IDLE) || (state_q == DONE));
    assign last_c   = (state_q == RUN) && ((cnt == CW'(WIDTH - 1)) || early_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (last_c) state_d = DONE;
            DONE:    state_d = accept_c ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags track the state being entered so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == RUN);
            done <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
        end else if (accept_c) begin
            acc   <= '0;
            mcand <= AW'(multiplicand);
            mplr  <= multiplier;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            acc   <= AW'(adder_result[PW-1:0]);
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= CW'(cnt + 1'b1);
        end
    end

    // Product is held across IDLE and only replaced by the final RUN sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            product <= '0;
        end else if (last_c) begin
            product <= adder_result[PW-1:0];
        end
    end

    // A carry out can never happen for a legal product, so it flags an adder fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (accept_c) begin
            err <= 1'b0;
        end else if ((state_q == RUN) && adder_cout) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier with a behavioural 32-bit adder.
// Expected latencies follow MUL_EARLY_EXIT_EN when it is defined.
module tb_seq_shift_add_multiplier;

    localparam int unsigned W = 16;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [31:0] prod;
        logic        err;
        int          lat;
        int          start_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic          busy;
    logic          done;
    logic [2*W-1:0] product;
    logic          err;
    logic [31:0]   adder_a;
    logic [31:0]   adder_b;
    logic          adder_cin;
    logic [31:0]   adder_result;
    logic          adder_cout;
    logic          raw_cout;
    logic          force_cout = 1'b0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    seq_shift_add_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .err          (err),
        .adder_a      (adder_a),
        .adder_b      (adder_b),
        .adder_cin    (adder_cin),
        .adder_result (adder_result),
        .adder_cout   (adder_cout)
    );

    // Behavioural adder with a fault-injection override on the carry.
    assign {raw_cout, adder_result} = 33'(adder_a) + 33'(adder_b) + 33'(adder_cin);
    assign adder_cout = raw_cout | force_cout;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_lat(input logic [W-1:0] b);
        int h = 0;
        for (int i = 0; i < int'(W); i++) if (b[i]) h = i;
        return EARLY ? h + 2 : int'(W) + 1;
    endfunction

    // Issue one accepted start; expectation is pushed at issue time.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [31:0] prod, input logic e);
        exp_t x;
        @(posedge clk); #1;
        start = 1'b1; multiplicand = a; multiplier = b;
        x.prod = prod; x.err = e; x.lat = exp_lat(b); x.start_cyc = cyc;
        sb.push_back(x);
        @(posedge clk); #1;
        start = 1'b0; multiplicand = '0; multiplier = '0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_run = 0;
            prev_done = 1'b0;
        end else begin
            if (busy) busy_run++;
            if (busy && raw_cout) chk("adder_carry_in_run", 32'd1, 32'd0);
            if (done) begin
                chk("busy_done_overlap", 32'(busy), 32'd0);
                chk("done_twice", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("product", product, e.prod);
                    chk("err", 32'(err), 32'(e.err));
                    chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
                    chk("busy_cycles", 32'(busy_run), 32'(e.lat - 1));
                end
                busy_run = 0;
            end
            prev_done = done;
        end
    end

    initial begin
        exp_t x;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", product, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_adder_a", adder_a, 32'd0);
        chk("rst_adder_b", adder_b, 32'd0);
        chk("rst_adder_cin", 32'(adder_cin), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(16'd3, 16'd5, 32'h0000_000F, 1'b0);
        wait_done();
        issue(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0);
        wait_done();
        issue(16'h1234, 16'h0000, 32'h0000_0000, 1'b0);
        wait_done();
        issue(16'hABCD, 16'h8001, 32'h55E7_2BCD, 1'b0);
        wait_done();

        // Start pulsed in RUN cycle 5 must be ignored.
        issue(16'h0012, 16'h0034, 32'h0000_03A8, 1'b0);
        repeat (4) @(posedge clk);
        #1 start = 1'b1; multiplicand = 16'hFFFF; multiplier = 16'hFFFF;
        @(posedge clk); #1 start = 1'b0; multiplicand = '0; multiplier = '0;
        wait_done();
        repeat (20) @(posedge clk);

        // Back-to-back: start held during the DONE cycle.
        issue(16'd2, 16'd3, 32'd6, 1'b0);
        wait_done();
        start = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
        x.prod = 32'd63; x.err = 1'b0; x.lat = exp_lat(16'd9); x.start_cyc = cyc;
        sb.push_back(x);
        @(posedge clk); #1 start = 1'b0; multiplicand = '0; multiplier = '0;
        wait_done();

        // Reset mid-RUN aborts and clears the product.
        issue(16'h00AB, 16'h0CDE, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", product, 32'd0);
        chk("abort_adder_a", adder_a, 32'd0);
        chk("abort_adder_b", adder_b, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(16'h0100, 16'h0010, 32'h0000_1000, 1'b0);
        wait_done();

        // Injected carry during RUN sets a sticky err.
        issue(16'd3, 16'd5, 32'h0000_000F, 1'b1);
        force_cout = 1'b1;
        @(posedge clk); #1 force_cout = 1'b0;
        wait_done();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        issue(16'd7, 16'd9, 32'd63, 1'b0);
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);
        wait_done();

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
